// File: rtl/pc_sequencer.sv
// MIPS program-counter sequencer: increment, signed branch redirect, absolute jump,
// stall hold and sticky halt, gated by the debug unit's idle/run/single-step control.
module pc_sequencer #(
  parameter int PC_LENGTH    = 11,
  parameter int COUNT_LENGTH = 32
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_mode_step,
  input  logic                    i_step,
  input  logic                    i_stall,
  input  logic                    i_branch_taken,
  input  logic [PC_LENGTH-1:0]    i_branch_base,
  input  logic [PC_LENGTH-1:0]    i_branch_offset,
  input  logic                    i_jump,
  input  logic [PC_LENGTH-1:0]    i_jump_addr,
  input  logic                    i_halt_detected,
  output logic [PC_LENGTH-1:0]    o_pc,
  output logic [PC_LENGTH-1:0]    o_pc_plus_one,
  output logic                    o_fetch_enable,
  output logic                    o_halted,
  output logic [1:0]              o_state,
  output logic [COUNT_LENGTH-1:0] o_advance_count
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RUN       = 2'b01,
    ST_STEP_WAIT = 2'b10,
    ST_HALTED    = 2'b11
  } state_e;

  localparam logic [PC_LENGTH-1:0] PC_ONE = {{(PC_LENGTH-1){1'b0}}, 1'b1};

  // Unsigned base plus sign-extended offset, wrapping modulo 2^PC_LENGTH.
  function automatic logic [PC_LENGTH-1:0] pc_add(
    input logic [PC_LENGTH-1:0] base,
    input logic [PC_LENGTH-1:0] offset
  );
    logic [PC_LENGTH:0] sum;
    sum = {1'b0, base} + {offset[PC_LENGTH-1], offset};
    return sum[PC_LENGTH-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [PC_LENGTH-1:0]    pc_q, pc_d;
  logic [COUNT_LENGTH-1:0] count_q, count_d;
  logic                    step_q;
  logic                    step_pulse_s;
  logic                    allowed_s;
  logic                    fetch_s;
  logic [PC_LENGTH-1:0]    branch_target_s;
  logic [PC_LENGTH-1:0]    pc_inc_s;

  assign step_pulse_s    = i_step & ~step_q;
  assign branch_target_s = pc_add(i_branch_base, i_branch_offset);
  assign pc_inc_s        = pc_q + PC_ONE;

  // State transitions and update-permission decode.
  always_comb begin
    state_d   = state_q;
    allowed_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = i_mode_step ? ST_STEP_WAIT : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt_detected) begin
          state_d = ST_HALTED;
        end else begin
          allowed_s = 1'b1;
        end
      end
      ST_STEP_WAIT: begin
        if (i_halt_detected) begin
          state_d = ST_HALTED;
        end else begin
          // A step edge seen during a stall still spends the step.
          allowed_s = step_pulse_s;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next-PC selection by priority: jump, branch, stall hold, increment.
  always_comb begin
    pc_d    = pc_q;
    fetch_s = 1'b0;
    if (allowed_s) begin
      if (i_jump) begin
        pc_d    = i_jump_addr;
        fetch_s = 1'b1;
      end else if (i_branch_taken) begin
        pc_d    = branch_target_s;
        fetch_s = 1'b1;
      end else if (i_stall) begin
        pc_d    = pc_q;
        fetch_s = 1'b0;
      end else begin
        pc_d    = pc_inc_s;
        fetch_s = 1'b1;
      end
    end else begin
      pc_d    = pc_q;
      fetch_s = 1'b0;
    end
  end

  // Retired-advance counter follows every PC write.
  always_comb begin
    count_d = count_q + {{(COUNT_LENGTH-1){1'b0}}, fetch_s};
  end

  // State, PC, counter and step-edge registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= {PC_LENGTH{1'b0}};
      count_q <= {COUNT_LENGTH{1'b0}};
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      step_q  <= i_step;
    end
  end

  assign o_pc            = pc_q;
  assign o_pc_plus_one   = pc_inc_s;
  assign o_fetch_enable  = fetch_s;
  assign o_halted        = (state_q == ST_HALTED);
  assign o_state         = state_q;
  assign o_advance_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, run, branch/jump, wrap, stall, step and halt.
module tb_pc_sequencer;
  localparam int PW = 11;
  localparam int CW = 32;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_start, i_mode_step, i_step, i_stall, i_branch_taken, i_jump, i_halt_detected;
  logic [PW-1:0] i_branch_base, i_branch_offset, i_jump_addr;
  logic [PW-1:0] o_pc, o_pc_plus_one;
  logic          o_fetch_enable, o_halted;
  logic [1:0]    o_state;
  logic [CW-1:0] o_advance_count;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.PC_LENGTH(PW), .COUNT_LENGTH(CW)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_mode_step(i_mode_step),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_base(i_branch_base), .i_branch_offset(i_branch_offset), .i_jump(i_jump),
    .i_jump_addr(i_jump_addr), .i_halt_detected(i_halt_detected), .o_pc(o_pc),
    .o_pc_plus_one(o_pc_plus_one), .o_fetch_enable(o_fetch_enable), .o_halted(o_halted),
    .o_state(o_state), .o_advance_count(o_advance_count)
  );

  always #5 i_clock = ~i_clock;

  task automatic clear_inputs();
    i_start = 1'b0; i_mode_step = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_branch_taken = 1'b0; i_jump = 1'b0; i_halt_detected = 1'b0;
    i_branch_base = 11'd0; i_branch_offset = 11'd0; i_jump_addr = 11'd0;
  endtask

  // Advance one edge; leaves time at posedge+1 for driving and sampling.
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    #2 i_reset = 1'b0;
    @(negedge i_clock);
    i_reset = 1'b1;
    tick();
  endtask

  task automatic start_run(input logic step_mode);
    do_reset();
    i_start = 1'b1; i_mode_step = step_mode;
    tick();
    i_start = 1'b0; i_mode_step = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1'b0;
    #3;
    n_checks++; if (o_pc !== 11'd0) $display("FAIL reset_pc got %0d exp 0", o_pc); else n_pass++;
    n_checks++; if (o_state !== 2'b00) $display("FAIL reset_state got %b exp 00", o_state); else n_pass++;
    n_checks++; if (o_advance_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", o_advance_count); else n_pass++;
    n_checks++; if (o_fetch_enable !== 1'b0 || o_halted !== 1'b0)
      $display("FAIL reset_flags got fe=%b h=%b exp 0 0", o_fetch_enable, o_halted); else n_pass++;
    @(negedge i_clock);
    i_reset = 1'b1;
    tick(); tick();
    n_checks++; if (o_pc !== 11'd0 || o_state !== 2'b00)
      $display("FAIL idle_frozen got pc=%0d st=%b exp 0 00", o_pc, o_state); else n_pass++;
  endtask

  task automatic test_run();
    start_run(1'b0);
    n_checks++; if (o_state !== 2'b01 || o_pc !== 11'd0)
      $display("FAIL run_enter got st=%b pc=%0d exp 01 0", o_state, o_pc); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (o_fetch_enable !== 1'b1) $display("FAIL run_fetch got %b exp 1", o_fetch_enable); else n_pass++;
      tick();
      n_checks++; if (o_pc !== PW'(k)) $display("FAIL run_pc got %0d exp %0d", o_pc, k); else n_pass++;
    end
    n_checks++; if (o_advance_count !== 32'd4) $display("FAIL run_count got %0d exp 4", o_advance_count); else n_pass++;
    n_checks++; if (o_pc_plus_one !== 11'd5) $display("FAIL run_plus_one got %0d exp 5", o_pc_plus_one); else n_pass++;
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (o_fetch_enable !== 1'b0) $display("FAIL stall_fetch got %b exp 0", o_fetch_enable); else n_pass++;
      tick();
      n_checks++; if (o_pc !== 11'd4) $display("FAIL stall_pc got %0d exp 4", o_pc); else n_pass++;
    end
    n_checks++; if (o_advance_count !== 32'd4) $display("FAIL stall_count got %0d exp 4", o_advance_count); else n_pass++;
    i_stall = 1'b0;
    tick();
    n_checks++; if (o_pc !== 11'd5) $display("FAIL unstall_pc got %0d exp 5", o_pc); else n_pass++;
    // Asynchronous reset between edges must clear everything at once.
    #2 i_reset = 1'b0;
    #1;
    n_checks++; if (o_pc !== 11'd0 || o_state !== 2'b00 || o_advance_count !== 32'd0)
      $display("FAIL async_reset got pc=%0d st=%b cnt=%0d exp 0 00 0", o_pc, o_state, o_advance_count); else n_pass++;
    @(negedge i_clock);
    i_reset = 1'b1;
    tick();
  endtask

  task automatic test_branch();
    start_run(1'b0);
    i_branch_taken = 1'b1; i_branch_base = 11'd10; i_branch_offset = 11'h7FD;
    #1;
    n_checks++; if (o_fetch_enable !== 1'b1) $display("FAIL branch_fetch got %b exp 1", o_fetch_enable); else n_pass++;
    tick();
    n_checks++; if (o_pc !== 11'd7) $display("FAIL branch_neg got %0d exp 7", o_pc); else n_pass++;
    i_branch_base = 11'd2047; i_branch_offset = 11'd2;
    tick();
    n_checks++; if (o_pc !== 11'd1) $display("FAIL branch_wrap_up got %0d exp 1", o_pc); else n_pass++;
    i_branch_base = 11'd1; i_branch_offset = 11'h7FC;
    tick();
    n_checks++; if (o_pc !== 11'd2045) $display("FAIL branch_wrap_down got %0d exp 2045", o_pc); else n_pass++;
    i_jump = 1'b1; i_jump_addr = 11'd300; i_branch_base = 11'd10; i_branch_offset = 11'd5;
    tick();
    n_checks++; if (o_pc !== 11'd300) $display("FAIL jump_over_branch got %0d exp 300", o_pc); else n_pass++;
    clear_inputs();
    tick();
    n_checks++; if (o_pc !== 11'd301 || o_advance_count !== 32'd5)
      $display("FAIL branch_after got pc=%0d cnt=%0d exp 301 5", o_pc, o_advance_count); else n_pass++;
    i_jump = 1'b1; i_jump_addr = 11'd2047;
    tick();
    i_jump = 1'b0;
    #1;
    n_checks++; if (o_pc_plus_one !== 11'd0) $display("FAIL plus_one_wrap got %0d exp 0", o_pc_plus_one); else n_pass++;
    tick();
    n_checks++; if (o_pc !== 11'd0) $display("FAIL inc_wrap got %0d exp 0", o_pc); else n_pass++;
  endtask

  task automatic test_stall_redirect();
    start_run(1'b0);
    i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 11'd100;
    #1;
    n_checks++; if (o_fetch_enable !== 1'b1) $display("FAIL stall_jump_fetch got %b exp 1", o_fetch_enable); else n_pass++;
    tick();
    n_checks++; if (o_pc !== 11'd100) $display("FAIL stall_jump_pc got %0d exp 100", o_pc); else n_pass++;
    i_jump = 1'b0; i_branch_taken = 1'b1; i_branch_base = 11'd50; i_branch_offset = 11'h7F6;
    tick();
    n_checks++; if (o_pc !== 11'd40) $display("FAIL stall_branch_pc got %0d exp 40", o_pc); else n_pass++;
    i_branch_taken = 1'b0;
    tick();
    n_checks++; if (o_pc !== 11'd40 || o_advance_count !== 32'd2)
      $display("FAIL stall_only got pc=%0d cnt=%0d exp 40 2", o_pc, o_advance_count); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_step();
    start_run(1'b1);
    n_checks++; if (o_state !== 2'b10) $display("FAIL step_state got %b exp 10", o_state); else n_pass++;
    i_step = 1'b1;
    #1;
    n_checks++; if (o_fetch_enable !== 1'b1) $display("FAIL step_edge_fetch got %b exp 1", o_fetch_enable); else n_pass++;
    tick();
    #1;
    n_checks++; if (o_fetch_enable !== 1'b0) $display("FAIL step_level_fetch got %b exp 0", o_fetch_enable); else n_pass++;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (o_pc !== 11'd1) $display("FAIL step_hold got %0d exp 1", o_pc); else n_pass++;
    i_step = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_step = 1'b1; tick();
      i_step = 1'b0; tick();
    end
    n_checks++; if (o_pc !== 11'd4) $display("FAIL step_toggle got %0d exp 4", o_pc); else n_pass++;
    for (int k = 0; k < 3; k++) tick();
    n_checks++; if (o_pc !== 11'd4) $display("FAIL step_idle got %0d exp 4", o_pc); else n_pass++;
    i_step = 1'b1; i_stall = 1'b1;
    tick();
    i_stall = 1'b0;
    tick();
    n_checks++; if (o_pc !== 11'd4 || o_advance_count !== 32'd4)
      $display("FAIL step_consumed got pc=%0d cnt=%0d exp 4 4", o_pc, o_advance_count); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_halt();
    start_run(1'b0);
    i_jump = 1'b1; i_jump_addr = 11'd9;
    tick();
    i_jump = 1'b0;
    i_halt_detected = 1'b1; i_branch_taken = 1'b1; i_branch_base = 11'd20; i_branch_offset = 11'd5;
    #1;
    n_checks++; if (o_fetch_enable !== 1'b0) $display("FAIL halt_fetch got %b exp 0", o_fetch_enable); else n_pass++;
    tick();
    n_checks++; if (o_state !== 2'b11 || o_halted !== 1'b1 || o_pc !== 11'd9)
      $display("FAIL halt_enter got st=%b h=%b pc=%0d exp 11 1 9", o_state, o_halted, o_pc); else n_pass++;
    clear_inputs();
    i_start = 1'b1; i_jump = 1'b1; i_jump_addr = 11'd77;
    for (int k = 0; k < 4; k++) begin
      i_step = ~i_step;
      tick();
    end
    n_checks++; if (o_state !== 2'b11 || o_pc !== 11'd9 || o_advance_count !== 32'd1)
      $display("FAIL halt_sticky got st=%b pc=%0d cnt=%0d exp 11 9 1", o_state, o_pc, o_advance_count); else n_pass++;
    do_reset();
    n_checks++; if (o_state !== 2'b00 || o_halted !== 1'b0)
      $display("FAIL halt_exit got st=%b h=%b exp 00 0", o_state, o_halted); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_branch();
    test_stall_redirect();
    test_step();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
